// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned NREGS      = 2 ** ADDR_W_DEF;

    // Width that can hold every count from 0 to nregs inclusive.
    function automatic int unsigned cnt_width(input int unsigned nregs);
        return $clog2(nregs + 1);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, write and reserve bus of the scoreboarded register file.
interface regfile_sb_if import regfile_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = cnt_width(NUM_REGS);

    logic [ADDR_W-1:0]   rd_addr1;
    logic [DATA_W-1:0]   rd_data1;
    logic                rd_rdy1;
    logic [ADDR_W-1:0]   rd_addr2;
    logic [DATA_W-1:0]   rd_data2;
    logic                rd_rdy2;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                rsv_en;
    logic [ADDR_W-1:0]   rsv_addr;
    logic                rsv_ok;
    logic [NUM_REGS-1:0] busy_vec;
    logic [CNT_W-1:0]    busy_cnt;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data1, rd_rdy1, rd_data2, rd_rdy2, rsv_ok, busy_vec, busy_cnt
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data1, rd_rdy1, rd_data2, rd_rdy2, rsv_ok, busy_vec, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-register scoreboard: busy flags, busy count and reserve acceptance.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic                          rsv_ok,
    output logic [2**ADDR_W-1:0]          busy_vec,
    output logic [cnt_width(2**ADDR_W)-1:0] busy_cnt
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = cnt_width(NUM_REGS);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_hit_rsv, set_busy, inc, dec;

    always_comb begin
        wr_hit_rsv = wr_en && (wr_addr == rsv_addr);
        rsv_ok     = rsv_en && reset_n && (!busy_q[rsv_addr] || wr_hit_rsv);
        set_busy   = rsv_ok && !(ZERO_REG && (rsv_addr == '0));
        inc        = set_busy && !busy_q[rsv_addr];
        // A write clearing the register being re-reserved is a net-zero change.
        dec        = wr_en && busy_q[wr_addr] && !(set_busy && wr_hit_rsv);

        busy_d = busy_q;
        if (wr_en) busy_d[wr_addr] = 1'b0;
        if (set_busy) busy_d[rsv_addr] = 1'b1;
        cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with pending scoreboard and write-to-read bypass.
module regfile_sb import regfile_pkg::*; #(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input logic         clk,
    input logic         reset_n,
    regfile_sb_if.slave bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_store, bypass_en;
    logic                hit1, hit2, zero1, zero2;

    assign wr_store  = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
    assign bypass_en = BYPASS && bus.wr_en && reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (wr_store) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        hit1         = bypass_en && (bus.wr_addr == bus.rd_addr1);
        zero1        = ZERO_REG && (bus.rd_addr1 == '0);
        bus.rd_data1 = regs[bus.rd_addr1];
        bus.rd_rdy1  = !busy[bus.rd_addr1];
        if (hit1) begin
            bus.rd_data1 = bus.wr_data;
            bus.rd_rdy1  = 1'b1;
        end
        if (zero1) begin
            bus.rd_data1 = '0;
            bus.rd_rdy1  = 1'b1;
        end
    end

    always_comb begin
        hit2         = bypass_en && (bus.wr_addr == bus.rd_addr2);
        zero2        = ZERO_REG && (bus.rd_addr2 == '0);
        bus.rd_data2 = regs[bus.rd_addr2];
        bus.rd_rdy2  = !busy[bus.rd_addr2];
        if (hit2) begin
            bus.rd_data2 = bus.wr_data;
            bus.rd_rdy2  = 1'b1;
        end
        if (zero2) begin
            bus.rd_data2 = '0;
            bus.rd_rdy2  = 1'b1;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .rsv_ok   (bus.rsv_ok),
        .busy_vec (busy),
        .busy_cnt (bus.busy_cnt)
    );

    assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default config (bypass) and zero-reg/no-bypass config side by side.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(2)) if_a ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(2)) if_b ();

    regfile_sb #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a)
    );
    regfile_sb #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b)
    );

    int total = 0;
    int bad   = 0;

    logic        s_rst_n, s_wr_en, s_rsv_en;
    logic [1:0]  s_wr_addr, s_rsv_addr, s_ra1, s_ra2;
    logic [15:0] s_wr_data;

    // Reference state per configuration: index 0 = u_a, 1 = u_b.
    logic [15:0] m_regs [2][4];
    logic [3:0]  m_busy [2];
    bit          zr  [2] = '{1'b0, 1'b1};
    bit          byp [2] = '{1'b1, 1'b0};

    typedef struct {
        logic        rst_n, wr_en;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic        rsv_en;
        logic [1:0]  ra, ra1, ra2;
        logic [15:0] d1;
        logic        r1;
        logic [15:0] d2;
        logic        r2, ok;
        logic [3:0]  bv;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, wr_en, input logic [1:0] wa,
                                input logic [15:0] wd, input logic rsv_en,
                                input logic [1:0] ra, ra1, ra2,
                                input logic [15:0] d1, input logic r1,
                                input logic [15:0] d2, input logic r2, ok,
                                input logic [3:0] bv, input logic [2:0] cnt);
        vec_t v;
        v.rst_n = rst_n; v.wr_en = wr_en; v.wa = wa; v.wd = wd;
        v.rsv_en = rsv_en; v.ra = ra; v.ra1 = ra1; v.ra2 = ra2;
        v.d1 = d1; v.r1 = r1; v.d2 = d2; v.r2 = r2; v.ok = ok;
        v.bv = bv; v.cnt = cnt;
        return v;
    endfunction

    task automatic apply();
        reset_n       = s_rst_n;
        if_a.wr_en    = s_wr_en;    if_b.wr_en    = s_wr_en;
        if_a.wr_addr  = s_wr_addr;  if_b.wr_addr  = s_wr_addr;
        if_a.wr_data  = s_wr_data;  if_b.wr_data  = s_wr_data;
        if_a.rsv_en   = s_rsv_en;   if_b.rsv_en   = s_rsv_en;
        if_a.rsv_addr = s_rsv_addr; if_b.rsv_addr = s_rsv_addr;
        if_a.rd_addr1 = s_ra1;      if_b.rd_addr1 = s_ra1;
        if_a.rd_addr2 = s_ra2;      if_b.rd_addr2 = s_ra2;
    endtask

    task automatic idle();
        s_rst_n = 1'b1; s_wr_en = 1'b0; s_wr_addr = 2'd0; s_wr_data = 16'h0;
        s_rsv_en = 1'b0; s_rsv_addr = 2'd0; s_ra1 = 2'd0; s_ra2 = 2'd0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_data(input bit c, input logic [1:0] a);
        if (zr[c] && a == 2'd0) return 16'h0;
        if (byp[c] && s_wr_en && s_rst_n && s_wr_addr == a) return s_wr_data;
        return m_regs[c][a];
    endfunction

    function automatic logic m_rdy(input bit c, input logic [1:0] a);
        if (zr[c] && a == 2'd0) return 1'b1;
        if (byp[c] && s_wr_en && s_rst_n && s_wr_addr == a) return 1'b1;
        return !m_busy[c][a];
    endfunction

    function automatic logic m_ok(input bit c);
        return s_rsv_en && s_rst_n &&
               (!m_busy[c][s_rsv_addr] || (s_wr_en && s_wr_addr == s_rsv_addr));
    endfunction

    task automatic m_update(input bit c, input logic ok);
        if (!s_rst_n) begin
            m_regs[c] = '{default: 16'h0};
            m_busy[c] = 4'b0;
        end else begin
            if (s_wr_en && !(zr[c] && s_wr_addr == 2'd0)) m_regs[c][s_wr_addr] = s_wr_data;
            if (s_wr_en) m_busy[c][s_wr_addr] = 1'b0;
            if (ok && !(zr[c] && s_rsv_addr == 2'd0)) m_busy[c][s_rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_model(input bit c, input logic [15:0] d1, input logic r1,
                               input logic [15:0] d2, input logic r2, input logic ok,
                               input logic [3:0] bv, input logic [2:0] cnt);
        string p;
        p = c ? "b." : "a.";
        check({p, "rd_data1"}, d1, m_data(c, s_ra1));
        check({p, "rd_rdy1"},  r1, m_rdy(c, s_ra1));
        check({p, "rd_data2"}, d2, m_data(c, s_ra2));
        check({p, "rd_rdy2"},  r2, m_rdy(c, s_ra2));
        check({p, "rsv_ok"},   ok, m_ok(c));
        check({p, "busy_vec"}, bv, m_busy[c]);
        check({p, "busy_cnt"}, cnt, $countones(m_busy[c]));
    endtask

    // Compare both DUTs against the model, then advance one clock.
    task automatic step();
        logic ok0, ok1;
        check_model(1'b0, if_a.rd_data1, if_a.rd_rdy1, if_a.rd_data2, if_a.rd_rdy2,
                    if_a.rsv_ok, if_a.busy_vec, if_a.busy_cnt);
        check_model(1'b1, if_b.rd_data1, if_b.rd_rdy1, if_b.rd_data2, if_b.rd_rdy2,
                    if_b.rsv_ok, if_b.busy_vec, if_b.busy_cnt);
        ok0 = m_ok(1'b0);
        ok1 = m_ok(1'b1);
        @(posedge clk);
        m_update(1'b0, ok0);
        m_update(1'b1, ok1);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;

        //             rst we wa wd        re ra a1 a2  d1        r1 d2        r2 ok bv       cnt
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 2, 3, 16'h0000, 1, 16'h0000, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 2, 16'h1234, 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 2, 2, 16'h1234, 1, 16'h1234, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 3, 16'hBEEF, 0, 0, 3, 2, 16'hBEEF, 1, 16'h1234, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 3, 16'h0000, 1, 16'hBEEF, 1, 1, 4'b0000, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0, 4'b0010, 1));
        vecs.push_back(mk(1, 1, 1, 16'h00AA, 0, 0, 1, 2, 16'h00AA, 1, 16'h1234, 1, 0, 4'b0010, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h00AA, 1, 16'h00AA, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h00AA, 1, 16'h0000, 1, 1, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 1, 16'h5555, 1, 1, 1, 2, 16'h5555, 1, 16'h1234, 1, 1, 4'b0010, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h5555, 0, 16'h5555, 0, 0, 4'b0010, 1));
        vecs.push_back(mk(1, 1, 0, 16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 1, 16'hFFFF, 1, 1, 4'b0010, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 2, 0, 1, 16'hFFFF, 0, 16'h5555, 0, 1, 4'b0011, 2));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 3, 2, 3, 16'h1234, 0, 16'hBEEF, 1, 1, 4'b0111, 3));
        vecs.push_back(mk(0, 1, 2, 16'h7777, 1, 0, 2, 3, 16'h1234, 0, 16'hBEEF, 0, 0, 4'b1111, 4));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h0000, 1, 16'h0000, 1, 0, 4'b0000, 0));

        idle();
        s_rst_n = 1'b0;
        apply();
        repeat (2) @(posedge clk);
        m_regs[0] = '{default: 16'h0}; m_regs[1] = '{default: 16'h0};
        m_busy[0] = 4'b0;              m_busy[1] = 4'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            v = vecs[i];
            s_rst_n = v.rst_n; s_wr_en = v.wr_en; s_wr_addr = v.wa; s_wr_data = v.wd;
            s_rsv_en = v.rsv_en; s_rsv_addr = v.ra; s_ra1 = v.ra1; s_ra2 = v.ra2;
            apply();
            #1;
            check($sformatf("tv%0d.rd_data1", i), if_a.rd_data1, v.d1);
            check($sformatf("tv%0d.rd_rdy1", i),  if_a.rd_rdy1,  v.r1);
            check($sformatf("tv%0d.rd_data2", i), if_a.rd_data2, v.d2);
            check($sformatf("tv%0d.rd_rdy2", i),  if_a.rd_rdy2,  v.r2);
            check($sformatf("tv%0d.rsv_ok", i),   if_a.rsv_ok,   v.ok);
            check($sformatf("tv%0d.busy_vec", i), if_a.busy_vec, v.bv);
            check($sformatf("tv%0d.busy_cnt", i), if_a.busy_cnt, v.cnt);
            step();
        end

        // Write clearing r2 while reserving r3: count stays, flag moves.
        idle(); s_rsv_en = 1'b1; s_rsv_addr = 2'd2;
        apply(); #1; step();
        idle(); s_wr_en = 1'b1; s_wr_addr = 2'd2; s_wr_data = 16'h0F0F;
        s_rsv_en = 1'b1; s_rsv_addr = 2'd3; s_ra1 = 2'd2;
        apply(); #1;
        check("swap.rsv_ok", if_a.rsv_ok, 1'b1);
        check("swap.cnt_before", if_a.busy_cnt, 3'd1);
        check("swap.rdy_bypass", if_a.rd_rdy1, 1'b1);
        check("swap.rdy_nobypass", if_b.rd_rdy1, 1'b0);
        step();
        idle(); s_ra1 = 2'd2; s_ra2 = 2'd3;
        apply(); #1;
        check("swap.busy_vec", if_a.busy_vec, 4'b1000);
        check("swap.cnt_after", if_a.busy_cnt, 3'd1);
        check("swap.rd_data1", if_a.rd_data1, 16'h0F0F);
        check("swap.rd_rdy2", if_a.rd_rdy2, 1'b0);
        step();

        for (int n = 0; n < 800; n++) begin
            s_rst_n    = ($urandom_range(0, 31) != 0);
            s_wr_en    = $urandom_range(0, 1) == 1;
            s_wr_addr  = 2'($urandom_range(0, 3));
            s_wr_data  = 16'($urandom);
            s_rsv_en   = $urandom_range(0, 1) == 1;
            s_rsv_addr = 2'($urandom_range(0, 3));
            s_ra1      = 2'($urandom_range(0, 3));
            s_ra2      = ($urandom_range(0, 3) == 0) ? s_ra1 : 2'($urandom_range(0, 3));
            apply();
            #1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
